// File: rtl/rf_wb_arbiter_if.sv
// Bundle of the arbiter's producer handshakes, register-file write port and decode hazard signals.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline's view.
interface rf_wb_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             i_a_valid;
  logic             o_a_ready;
  logic [4:0]       i_a_waddr;
  logic [31:0]      i_a_wdata;
  logic             i_b_valid;
  logic             o_b_ready;
  logic [4:0]       i_b_waddr;
  logic [31:0]      i_b_wdata;
  logic             i_wb_stall;
  logic             o_rd_wen;
  logic [4:0]       o_rd_waddr;
  logic [31:0]      o_rd_wdata;
  logic [4:0]       i_rs1_raddr;
  logic [4:0]       i_rs2_raddr;
  logic             o_rs1_pending;
  logic             o_rs2_pending;
  logic [31:0]      o_rs1_fwd_data;
  logic [31:0]      o_rs2_fwd_data;
  logic [CNT_W-1:0] o_count;

  modport slave (
    input  i_a_valid, i_a_waddr, i_a_wdata,
    input  i_b_valid, i_b_waddr, i_b_wdata,
    input  i_wb_stall, i_rs1_raddr, i_rs2_raddr,
    output o_a_ready, o_b_ready,
    output o_rd_wen, o_rd_waddr, o_rd_wdata,
    output o_rs1_pending, o_rs2_pending, o_rs1_fwd_data, o_rs2_fwd_data,
    output o_count
  );

  modport master (
    output i_a_valid, i_a_waddr, i_a_wdata,
    output i_b_valid, i_b_waddr, i_b_wdata,
    output i_wb_stall, i_rs1_raddr, i_rs2_raddr,
    input  o_a_ready, o_b_ready,
    input  o_rd_wen, o_rd_waddr, o_rd_wdata,
    input  o_rs1_pending, o_rs2_pending, o_rs1_fwd_data, o_rs2_fwd_data,
    input  o_count
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: two producers (A has priority) feed an in-order FIFO drained one entry
// per cycle onto the register-file write port, with pending/forwarding lookup for decode.
module rf_wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  rf_wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             full, empty;
  logic             a_fire, b_fire;
  logic             push, pop;
  logic [4:0]       push_addr;
  logic [31:0]      push_data;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    empty     = (count_q == '0);
    a_fire    = bus.i_a_valid && !full;
    b_fire    = bus.i_b_valid && !full && !bus.i_a_valid;
    push_addr = a_fire ? bus.i_a_waddr : bus.i_b_waddr;
    push_data = a_fire ? bus.i_a_wdata : bus.i_b_wdata;
    // x0 transfers still handshake but are dropped here.
    push      = (a_fire || b_fire) && (push_addr != 5'd0);
    pop       = !empty && !bus.i_wb_stall;

    head_d    = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d    = push ? tail_q + PTR_W'(1) : tail_q;
    count_d   = count_q;
    if (push && !pop) count_d = count_q + CNT_W'(1);
    if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  assign bus.o_a_ready  = !full;
  assign bus.o_b_ready  = !full && !bus.i_a_valid;
  assign bus.o_rd_wen   = pop;
  assign bus.o_rd_waddr = empty ? 5'd0  : addr_mem[head_q];
  assign bus.o_rd_wdata = empty ? 32'd0 : data_mem[head_q];
  assign bus.o_count    = count_q;

  // Walk valid entries oldest to youngest so the last match seen is the youngest one.
  logic [PTR_W-1:0] idx;
  logic             rs1_hit, rs2_hit;
  logic [31:0]      rs1_fwd, rs2_fwd;

  always_comb begin
    idx     = head_q;
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    rs1_fwd = '0;
    rs2_fwd = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (bus.i_rs1_raddr != 5'd0 && addr_mem[idx] == bus.i_rs1_raddr) begin
          rs1_hit = 1'b1;
          rs1_fwd = data_mem[idx];
        end
        if (bus.i_rs2_raddr != 5'd0 && addr_mem[idx] == bus.i_rs2_raddr) begin
          rs2_hit = 1'b1;
          rs2_fwd = data_mem[idx];
        end
      end
    end
  end

  assign bus.o_rs1_pending  = rs1_hit;
  assign bus.o_rs2_pending  = rs2_hit;
  assign bus.o_rs1_fwd_data = rs1_fwd;
  assign bus.o_rs2_fwd_data = rs2_fwd;

  // NOTE: sequential state is updated with non-blocking assignments only; all next-state math stays in always_comb.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; occupancy comes from the pointers and count,
  // so stale contents are never visible on any output.
  always_ff @(posedge i_clk) begin
    if (push) begin
      addr_mem[tail_q] <= push_addr;
      data_mem[tail_q] <= push_data;
    end
  end
endmodule
